// File: rtl/fcpu_pkg.sv
// Shared CPU types: widths, the reservation-station entry, opcodes and the commit-stage classification.
package fcpu_pkg;

  localparam int RSV_ID_W   = 4;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int INSTR_W    = 32;
  localparam int OPCODE_W   = 6;

  localparam logic [OPCODE_W-1:0] OP_NOP   = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 6'd1;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 6'd2;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'd3;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 6'd4;
  localparam logic [OPCODE_W-1:0] OP_STORE = 6'd5;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'd6;
  localparam logic [OPCODE_W-1:0] OP_JMP   = 6'd7;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 6'd8;

  typedef struct packed {
    logic [RSV_ID_W-1:0]   station_id;
    logic                  valid;
    logic                  ready;
    logic [REG_ADDR_W-1:0] dst_reg;
    logic [OPCODE_W-1:0]   opcode;
    logic [DATA_W-1:0]     content;
  } station_t;

  typedef enum logic [1:0] {
    CC_REG,
    CC_STORE,
    CC_NONE,
    CC_HALT
  } commit_class_t;

  typedef enum logic [1:0] {
    RUN,
    STORE_WAIT,
    HALTED
  } commit_state_t;

  function automatic commit_class_t commit_class(input logic [OPCODE_W-1:0] opcode);
    commit_class_t cc;
    case (opcode)
      OP_ADD, OP_SUB, OP_ADDI, OP_LOAD: cc = CC_REG;
      OP_STORE:                         cc = CC_STORE;
      OP_HALT:                          cc = CC_HALT;
      default:                          cc = CC_NONE;
    endcase
    return cc;
  endfunction

endpackage

// File: rtl/commit_unit.sv
// In-order commit stage: retires ROB head entries into register writes, store releases or halt.
// Optional FCPU_RETIRE_COUNT_EN adds a 32-bit retire counter port.
//
// state      | meaning
// RUN        | accepting one head entry per cycle
// STORE_WAIT | store release pending, waiting for store buffer ack
// HALTED     | halt retired, frozen until reset
module commit_unit
  import fcpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i_valid,
  input  station_t              i_commit_data,
  output logic                  i_ready,
  output logic                  reg_we,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0]     reg_data,
  output logic [RSV_ID_W-1:0]   reg_rsv_id,
  output logic                  st_commit_valid,
  output logic [RSV_ID_W-1:0]   st_commit_id,
  input  logic                  st_commit_ready,
`ifdef FCPU_RETIRE_COUNT_EN
  output logic [31:0]           retire_count,
`endif
  output logic                  halted
);

  commit_state_t state;
  logic          accept;
  commit_class_t cls;
  logic          unused_fields;

  // Held low while nrst is asserted so the ROB never sees a handshake during reset.
  assign i_ready       = nrst && (state == RUN);
  assign accept        = i_valid && (state == RUN);
  assign cls           = commit_class(i_commit_data.opcode);
  assign unused_fields = ^{i_commit_data.valid, i_commit_data.ready};

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state           <= RUN;
      reg_we          <= 1'b0;
      reg_addr        <= '0;
      reg_data        <= '0;
      reg_rsv_id      <= '0;
      st_commit_valid <= 1'b0;
      st_commit_id    <= '0;
      halted          <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            case (cls)
              CC_REG: begin
                // r0 is hardwired; the entry retires without a write.
                if (i_commit_data.dst_reg != '0) begin
                  reg_we     <= 1'b1;
                  reg_addr   <= i_commit_data.dst_reg;
                  reg_data   <= i_commit_data.content;
                  reg_rsv_id <= i_commit_data.station_id;
                end
              end
              CC_STORE: begin
                st_commit_valid <= 1'b1;
                st_commit_id    <= i_commit_data.station_id;
                state           <= STORE_WAIT;
              end
              CC_HALT: begin
                halted <= 1'b1;
                state  <= HALTED;
              end
              default: ;
            endcase
          end
        end
        STORE_WAIT: begin
          if (st_commit_ready) begin
            st_commit_valid <= 1'b0;
            state           <= RUN;
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

`ifdef FCPU_RETIRE_COUNT_EN
  always_ff @(posedge clk) begin
    if (!nrst) retire_count <= '0;
    else if (accept) retire_count <= retire_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Directed self-checking bench for commit_unit (works with or without FCPU_RETIRE_COUNT_EN).
module tb_commit_unit;
  import fcpu_pkg::*;

  logic                  clk = 1'b0;
  logic                  nrst;
  logic                  i_valid;
  station_t              i_commit_data;
  logic                  i_ready;
  logic                  reg_we;
  logic [REG_ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0]     reg_data;
  logic [RSV_ID_W-1:0]   reg_rsv_id;
  logic                  st_commit_valid;
  logic [RSV_ID_W-1:0]   st_commit_id;
  logic                  st_commit_ready;
  logic                  halted;
`ifdef FCPU_RETIRE_COUNT_EN
  logic [31:0]           retire_count;
`endif

  int errors = 0;
  int checks = 0;

  commit_unit dut (
    .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_commit_data(i_commit_data),
    .i_ready(i_ready), .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
    .reg_rsv_id(reg_rsv_id), .st_commit_valid(st_commit_valid),
    .st_commit_id(st_commit_id), .st_commit_ready(st_commit_ready),
`ifdef FCPU_RETIRE_COUNT_EN
    .retire_count(retire_count),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string tag, input logic [31:0] exp);
`ifdef FCPU_RETIRE_COUNT_EN
    check(tag, retire_count, exp);
`else
    if (exp === 32'hFFFF_FFFF) $display("unused %s", tag);
`endif
  endtask

  function automatic station_t entry(input logic [RSV_ID_W-1:0] id, input logic [REG_ADDR_W-1:0] dst,
                                     input logic [OPCODE_W-1:0] opc, input logic [DATA_W-1:0] content);
    station_t e;
    e.station_id = id;
    e.valid      = 1'b1;
    e.ready      = 1'b1;
    e.dst_reg    = dst;
    e.opcode     = opc;
    e.content    = content;
    return e;
  endfunction

  initial begin
    nrst = 1'b0;
    i_valid = 1'b0;
    i_commit_data = '0;
    st_commit_ready = 1'b0;
    tick();
    tick();
    check("rst_i_ready", {31'd0, i_ready}, 32'd0);
    check("rst_reg_we", {31'd0, reg_we}, 32'd0);
    check("rst_reg_addr", {27'd0, reg_addr}, 32'd0);
    check("rst_reg_data", reg_data, 32'd0);
    check("rst_st_valid", {31'd0, st_commit_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check_count("rst_count", 32'd0);
    nrst = 1'b1;
    #1;
    check("post_rst_i_ready", {31'd0, i_ready}, 32'd1);

    // single register write
    i_valid = 1'b1;
    i_commit_data = entry(4'd3, 5'd5, OP_ADD, 32'hDEADBEEF);
    tick();
    i_valid = 1'b0;
    check("reg1_we", {31'd0, reg_we}, 32'd1);
    check("reg1_addr", {27'd0, reg_addr}, 32'd5);
    check("reg1_data", reg_data, 32'hDEADBEEF);
    check("reg1_rsv", {28'd0, reg_rsv_id}, 32'd3);
    tick();
    check("reg1_we_drop", {31'd0, reg_we}, 32'd0);

    // four back-to-back register commits
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1;
      i_commit_data = entry(RSV_ID_W'(k + 4), REG_ADDR_W'(k + 1), OP_SUB, 32'h100 + k);
      #1;
      check("b2b_i_ready", {31'd0, i_ready}, 32'd1);
      tick();
      check("b2b_we", {31'd0, reg_we}, 32'd1);
      check("b2b_addr", {27'd0, reg_addr}, 32'(k + 1));
      check("b2b_data", reg_data, 32'h100 + k);
      check("b2b_rsv", {28'd0, reg_rsv_id}, 32'(k + 4));
    end
    i_valid = 1'b0;
    tick();
    check("b2b_we_drop", {31'd0, reg_we}, 32'd0);
    check_count("b2b_count", 32'd5);

    // store with delayed ack; a register entry waits behind it
    i_valid = 1'b1;
    i_commit_data = entry(4'd7, 5'd0, OP_STORE, 32'h0);
    tick();
    i_commit_data = entry(4'd2, 5'd9, OP_LOAD, 32'h55AA);
    check("st_valid", {31'd0, st_commit_valid}, 32'd1);
    check("st_id", {28'd0, st_commit_id}, 32'd7);
    check("st_i_ready", {31'd0, i_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("st_wait_valid", {31'd0, st_commit_valid}, 32'd1);
      check("st_wait_id", {28'd0, st_commit_id}, 32'd7);
      check("st_wait_i_ready", {31'd0, i_ready}, 32'd0);
      check("st_wait_no_we", {31'd0, reg_we}, 32'd0);
    end
    st_commit_ready = 1'b1;
    tick();
    st_commit_ready = 1'b0;
    check("st_done_valid", {31'd0, st_commit_valid}, 32'd0);
    check("st_done_i_ready", {31'd0, i_ready}, 32'd1);
    tick();
    i_valid = 1'b0;
    check("after_st_we", {31'd0, reg_we}, 32'd1);
    check("after_st_addr", {27'd0, reg_addr}, 32'd9);
    check("after_st_data", reg_data, 32'h55AA);
    check_count("st_count", 32'd7);

    // stray store ack while running is ignored
    st_commit_ready = 1'b1;
    tick();
    st_commit_ready = 1'b0;
    check("stray_ack_valid", {31'd0, st_commit_valid}, 32'd0);
    check("stray_ack_i_ready", {31'd0, i_ready}, 32'd1);

    // write to r0 retires without a strobe
    i_valid = 1'b1;
    i_commit_data = entry(4'd1, 5'd0, OP_ADDI, 32'h1234);
    tick();
    i_valid = 1'b0;
    check("r0_we", {31'd0, reg_we}, 32'd0);
    check("r0_i_ready", {31'd0, i_ready}, 32'd1);
    check_count("r0_count", 32'd8);

    // branch retires with no side output
    i_valid = 1'b1;
    i_commit_data = entry(4'd6, 5'd3, OP_BEQ, 32'h77);
    tick();
    i_valid = 1'b0;
    check("none_we", {31'd0, reg_we}, 32'd0);
    check("none_st", {31'd0, st_commit_valid}, 32'd0);
    check_count("none_count", 32'd9);

    // halt freezes commit
    i_valid = 1'b1;
    i_commit_data = entry(4'd8, 5'd0, OP_HALT, 32'h0);
    tick();
    i_commit_data = entry(4'd9, 5'd6, OP_ADD, 32'hCAFE);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_i_ready", {31'd0, i_ready}, 32'd0);
    tick();
    tick();
    check("halt_no_we", {31'd0, reg_we}, 32'd0);
    check("halt_still", {31'd0, halted}, 32'd1);
    check_count("halt_count", 32'd10);
    i_valid = 1'b0;
    nrst = 1'b0;
    tick();
    check("halt_rst_halted", {31'd0, halted}, 32'd0);
    nrst = 1'b1;
    #1;
    check("halt_rst_i_ready", {31'd0, i_ready}, 32'd1);
    check_count("halt_rst_count", 32'd0);

    // reset during STORE_WAIT
    i_valid = 1'b1;
    i_commit_data = entry(4'd11, 5'd0, OP_STORE, 32'h0);
    tick();
    i_valid = 1'b0;
    check("rst_st_pre_valid", {31'd0, st_commit_valid}, 32'd1);
    check("rst_st_pre_id", {28'd0, st_commit_id}, 32'd11);
    nrst = 1'b0;
    tick();
    check("rst_st_valid_drop", {31'd0, st_commit_valid}, 32'd0);
    check("rst_st_id_zero", {28'd0, st_commit_id}, 32'd0);
    check("rst_st_addr", {27'd0, reg_addr}, 32'd0);
    check("rst_st_data", reg_data, 32'd0);
    check("rst_st_rsv", {28'd0, reg_rsv_id}, 32'd0);
    check("rst_st_i_ready", {31'd0, i_ready}, 32'd0);
    nrst = 1'b1;
    #1;
    check("rst_st_run", {31'd0, i_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
